ecc_scrub_ctrl_28_22: RTL and testbench
=======================================

Name: ecc_scrub_ctrl_28_22

Overview:
Background scrubber for a RAM that stores 28-bit inverted SECDED(28,22) codewords.
- Periodically walks every address and reads the word through the 28/22 inverted decoder.
- On a correctable error, re-encodes the corrected data and writes it back. On an uncorrectable error, logs it and leaves the word untouched.
- Sits on a secondary port of the memory arbiter; yields to functional traffic via the req/gnt handshake.

Parameters:
- Depth, 1024, number of RAM words scrubbed (>=2).
- AddrW, $clog2(Depth), address width.
- IntervalW, 16, width of inter-access delay counter.
- CntW, 16, width of saturating error counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- enable_i  in  1  scrubbing enabled; sampled each cycle
- interval_i  in  IntervalW  idle cycles between word accesses
- req_o  out  1  memory request
- gnt_i  in  1  request accepted this cycle
- we_o  out  1  1=write, 0=read; valid with req_o
- addr_o  out  AddrW  word address; valid with req_o
- wdata_o  out  28  codeword to write; valid with req_o & we_o
- rvalid_i  in  1  read data valid (1+ cycles after read grant)
- rdata_i  in  28  read codeword
- busy_o  out  1  FSM not in IDLE
- pass_done_o  out  1  1-cycle pulse when last address finishes
- corr_cnt_o  out  CntW  saturating count of corrected words
- uncorr_cnt_o  out  CntW  saturating count of uncorrectable words
- err_addr_o  out  AddrW  address of most recent uncorrectable error
- uncorr_o  out  1  1-cycle pulse on uncorrectable detection

Behaviour:
- Reset values: req_o=0, we_o=0, addr_o=0, wdata_o=28'h0, busy_o=0, pass_done_o=0, corr_cnt_o=0, uncorr_cnt_o=0, err_addr_o=0, uncorr_o=0. Internal address pointer=0, delay counter=0.
- FSM states: IDLE, DELAY, RD_REQ, RD_WAIT, WR_REQ, ADVANCE.
- IDLE:
  - If enable_i=1, go to DELAY and load the delay counter with interval_i.
- DELAY:
  - Decrement each cycle.
  - When count==0, go to RD_REQ; interval_i=0 means no idle cycles.
  - If enable_i=0, go to IDLE.
- RD_REQ:
  - req_o=1, we_o=0, addr_o=ptr.
  - Hold req/addr stable until gnt_i=1, then go to RD_WAIT.
  - A request is never withdrawn before grant, even if enable_i drops.
- RD_WAIT:
  - Wait for rvalid_i and capture rdata_i into the decoder input register.
  - The decoder path is combinational from that register; classify the word on the next cycle.
  - err[1]=1 (double error): pulse uncorr_o, err_addr_o<=ptr, uncorr_cnt_o+=1 (saturate), go to ADVANCE.
  - err[0]=1 (single error, data or check bit): corr_cnt_o+=1 (saturate), wdata_o<=encode(corrected data), go to WR_REQ.
  - err=0: go to ADVANCE.
- WR_REQ:
  - req_o=1, we_o=1, addr_o=ptr, wdata_o held.
  - Hold until gnt_i=1, then go to ADVANCE.
- ADVANCE:
  - If ptr==Depth-1: ptr<=0 and pulse pass_done_o. Otherwise ptr+=1.
  - Then go to DELAY (reload interval_i) if enable_i=1, else IDLE.
- Counters stick at 2^CntW-1 and are never cleared except by reset.
- The 22-bit corrected data is re-encoded with the inverted encoder (check bits XORed with 28'ha800000 pattern). The inversion guarantees an all-zero RAM reads as uncorrectable or correctable, never as clean.
- ptr is retained across enable toggles; scrubbing resumes where it stopped.
- rvalid_i outside RD_WAIT is ignored.
- Async reset at any point aborts immediately: no further req_o. A partially granted write is the arbiter's concern.
- Latency, clean word, interval 0, gnt and rvalid immediate: DELAY 1 cycle, RD_REQ 1, RD_WAIT 1, classify 1, ADVANCE 1, i.e. 5 cycles per word.

Decomposition:
- Shared package ecc_scrub_pkg:
  - FSM state enum.
  - Code constants: data width 22, codeword width 28, syndrome width 6, inversion mask 28'ha800000.
- Instantiate the existing primitives prim_secded_inv_28_22_dec (on captured read data) and prim_secded_inv_28_22_enc (write-back). No new sub-module.
- Counters inline.

Test Plan:
1. Depth=4, clean encoded words at all addresses, interval 0, gnt/rvalid immediate -> four reads, no writes, pass_done_o pulses once after addr 3, counters stay 0.
2. Addr 2 holds enc(22'h155555) with bit 5 flipped -> write to addr 2 with wdata_o=enc(22'h155555), corr_cnt_o=1.
3. Addr 1 has check bit 24 flipped -> write-back of the original codeword, corr_cnt_o=1, uncorr_cnt_o=0.
4. Addr 3 has data bits 0 and 7 flipped -> no write, uncorr_o pulses, err_addr_o=3, uncorr_cnt_o=1.
5. gnt_i held low 10 cycles during RD_REQ with enable_i dropped mid-wait -> req_o/addr_o stable until grant, word completes, then IDLE; re-enable resumes at the next address.
6. Reset asserted during WR_REQ -> all outputs return to reset values asynchronously; after release with enable_i=1, scrub restarts at addr 0. Separately, CntW=2 with 5 corrected words -> corr_cnt_o saturates at 3.

Source files
------------

// File: rtl/ecc_scrub_pkg.sv
// Shared types and code constants for the SECDED(28,22) inverted-code scrubber.
package ecc_scrub_pkg;

  localparam int unsigned DataW = 22;
  localparam int unsigned CodeW = 28;
  localparam int unsigned SynW  = 6;
  localparam logic [CodeW-1:0] InvMask = 28'ha800000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_ADVANCE
  } scrub_state_e;

endpackage

// File: rtl/prim_secded_inv_28_22_dec.sv
// Hsiao SECDED(28,22) decoder for inverted codewords; corrects single-bit data errors.
module prim_secded_inv_28_22_dec (
  input  logic [27:0] data_i,
  output logic [21:0] data_o,
  output logic [5:0]  syndrome_o,
  output logic [1:0]  err_o
);

  localparam logic [21:0] M0 = 22'h3003ff;
  localparam logic [21:0] M1 = 22'h10fc0f;
  localparam logic [21:0] M2 = 22'h271c71;
  localparam logic [21:0] M3 = 22'h3b6592;
  localparam logic [21:0] M4 = 22'h3daaa4;
  localparam logic [21:0] M5 = 22'h3ed348;

  logic [27:0] d;

  assign d = data_i ^ 28'ha800000;

  assign syndrome_o[0] = d[22] ^ (^(d[21:0] & M0));
  assign syndrome_o[1] = d[23] ^ (^(d[21:0] & M1));
  assign syndrome_o[2] = d[24] ^ (^(d[21:0] & M2));
  assign syndrome_o[3] = d[25] ^ (^(d[21:0] & M3));
  assign syndrome_o[4] = d[26] ^ (^(d[21:0] & M4));
  assign syndrome_o[5] = d[27] ^ (^(d[21:0] & M5));

  for (genvar i = 0; i < 22; i++) begin : g_corr
    assign data_o[i] = d[i] ^ (syndrome_o == {M5[i], M4[i], M3[i], M2[i], M1[i], M0[i]});
  end

  // Odd syndrome weight is a single error; even non-zero weight is a double error.
  assign err_o[0] = ^syndrome_o;
  assign err_o[1] = ~err_o[0] & (|syndrome_o);

endmodule

// File: rtl/prim_secded_inv_28_22_enc.sv
// Hsiao SECDED(28,22) encoder with inverted check bits.
module prim_secded_inv_28_22_enc (
  input  logic [21:0] data_i,
  output logic [27:0] data_o
);

  localparam logic [21:0] M0 = 22'h3003ff;
  localparam logic [21:0] M1 = 22'h10fc0f;
  localparam logic [21:0] M2 = 22'h271c71;
  localparam logic [21:0] M3 = 22'h3b6592;
  localparam logic [21:0] M4 = 22'h3daaa4;
  localparam logic [21:0] M5 = 22'h3ed348;

  logic [5:0] chk;

  assign chk[0] = ^(data_i & M0);
  assign chk[1] = ^(data_i & M1);
  assign chk[2] = ^(data_i & M2);
  assign chk[3] = ^(data_i & M3);
  assign chk[4] = ^(data_i & M4);
  assign chk[5] = ^(data_i & M5);

  // Inverting check bits 23/25/27 keeps an all-zero word from decoding as clean.
  assign data_o = {chk, data_i} ^ 28'ha800000;

endmodule

// File: rtl/ecc_scrub_ctrl_28_22.sv
// Background scrubber: walks every RAM word, writes back corrected single-bit
// errors and logs uncorrectable ones, yielding to functional traffic via req/gnt.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | scrubbing disabled, waiting for enable_i
// ST_DELAY   | counting down interval_i idle cycles before the next word
// ST_RD_REQ  | read request held at ptr until granted
// ST_RD_WAIT | waiting for rvalid_i, then one cycle to classify the word
// ST_WR_REQ  | write-back of the corrected codeword held until granted
// ST_ADVANCE | step the address pointer, pulse pass_done_o on wrap
module ecc_scrub_ctrl_28_22
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned Depth     = 1024,
  parameter int unsigned AddrW     = $clog2(Depth),
  parameter int unsigned IntervalW = 16,
  parameter int unsigned CntW      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [IntervalW-1:0] interval_i,
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic                 we_o,
  output logic [AddrW-1:0]     addr_o,
  output logic [CodeW-1:0]     wdata_o,
  input  logic                 rvalid_i,
  input  logic [CodeW-1:0]     rdata_i,
  output logic                 busy_o,
  output logic                 pass_done_o,
  output logic [CntW-1:0]      corr_cnt_o,
  output logic [CntW-1:0]      uncorr_cnt_o,
  output logic [AddrW-1:0]     err_addr_o,
  output logic                 uncorr_o
);

  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);
  localparam logic [CntW-1:0]  CntMax   = '1;

  scrub_state_e state_q, state_d;

  logic [AddrW-1:0]     ptr_q;
  logic [IntervalW-1:0] delay_q;
  logic [CodeW-1:0]     rd_q;
  logic                 dec_valid_q;
  logic [CodeW-1:0]     wdata_q;
  logic [CntW-1:0]      corr_cnt_q;
  logic [CntW-1:0]      uncorr_cnt_q;
  logic [AddrW-1:0]     err_addr_q;

  logic [DataW-1:0] dec_data;
  logic [SynW-1:0]  dec_syn;
  logic [1:0]       dec_err;
  logic [CodeW-1:0] enc_word;
  logic             unused_syn;

  logic load_delay;
  logic capture;
  logic classify;
  logic last_addr;

  prim_secded_inv_28_22_dec u_dec (
    .data_i     (rd_q),
    .data_o     (dec_data),
    .syndrome_o (dec_syn),
    .err_o      (dec_err)
  );

  prim_secded_inv_28_22_enc u_enc (
    .data_i (dec_data),
    .data_o (enc_word)
  );

  assign unused_syn = ^dec_syn;

  // Capture and classification are split so the decoder only sees registered data.
  assign capture    = (state_q == ST_RD_WAIT) && !dec_valid_q && rvalid_i;
  assign classify   = (state_q == ST_RD_WAIT) && dec_valid_q;
  assign last_addr  = (ptr_q == LastAddr);
  assign load_delay = (state_d == ST_DELAY) && (state_q != ST_DELAY);

  always_comb begin
    state_d = state_q;
    req_o   = 1'b0;
    we_o    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_DELAY;
      end
      ST_DELAY: begin
        if (!enable_i)            state_d = ST_IDLE;
        else if (delay_q == '0)   state_d = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        req_o = 1'b1;
        if (gnt_i) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (classify) begin
          if (dec_err[1])      state_d = ST_ADVANCE;
          else if (dec_err[0]) state_d = ST_WR_REQ;
          else                 state_d = ST_ADVANCE;
        end
      end
      ST_WR_REQ: begin
        req_o = 1'b1;
        we_o  = 1'b1;
        if (gnt_i) state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        state_d = enable_i ? ST_DELAY : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      delay_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_delay) begin
        delay_q <= interval_i;
      end else if ((state_q == ST_DELAY) && (delay_q != '0)) begin
        delay_q <= delay_q - IntervalW'(1);
      end
      if (state_q == ST_ADVANCE) begin
        ptr_q <= last_addr ? '0 : ptr_q + AddrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q        <= '0;
      dec_valid_q <= 1'b0;
    end else if (capture) begin
      rd_q        <= rdata_i;
      dec_valid_q <= 1'b1;
    end else if (classify) begin
      dec_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdata_q      <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      err_addr_q   <= '0;
    end else if (classify) begin
      if (dec_err[1]) begin
        err_addr_q <= ptr_q;
        if (uncorr_cnt_q != CntMax) uncorr_cnt_q <= uncorr_cnt_q + CntW'(1);
      end else if (dec_err[0]) begin
        wdata_q <= enc_word;
        if (corr_cnt_q != CntMax) corr_cnt_q <= corr_cnt_q + CntW'(1);
      end
    end
  end

  assign addr_o       = ptr_q;
  assign wdata_o      = wdata_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign pass_done_o  = (state_q == ST_ADVANCE) && last_addr;
  assign uncorr_o     = classify && dec_err[1];
  assign corr_cnt_o   = corr_cnt_q;
  assign uncorr_cnt_o = uncorr_cnt_q;
  assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl_28_22.sv
// Directed bench for ecc_scrub_ctrl_28_22 with a 4-word memory model and a CntW=2 twin.
module tb_ecc_scrub_ctrl_28_22;

  // Hand-computed inverted codewords
  localparam logic [27:0] ENC_0      = 28'ha800000; // enc(22'h0)
  localparam logic [27:0] ENC_1      = 28'hb400001; // enc(22'h1)
  localparam logic [27:0] ENC_2      = 28'h8400002; // enc(22'h2)
  localparam logic [27:0] ENC_155555 = 28'hb955555; // enc(22'h155555)

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        enable = 1'b0;
  logic [15:0] interval = 16'd0;
  logic        req, gnt, we, busy, pass_done, uncorr;
  logic [1:0]  addr, err_addr;
  logic [27:0] wdata;
  logic        rvalid = 1'b0;
  logic [27:0] rdata = '0;
  logic [15:0] corr_cnt, uncorr_cnt;
  logic        gnt_rd_en = 1'b1;
  logic        gnt_wr_en = 1'b1;

  logic [27:0] mem [4];
  int          rd_cnt = 0, wr_cnt = 0, pass_cnt = 0, uncorr_pulses = 0;
  logic [1:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [27:0] last_wr_data = '0;

  int n_assert = 0;
  int n_fail = 0;

  assign gnt = req & (we ? gnt_wr_en : gnt_rd_en);

  ecc_scrub_ctrl_28_22 #(.Depth(4), .IntervalW(16), .CntW(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .interval_i   (interval),
    .req_o        (req),
    .gnt_i        (gnt),
    .we_o         (we),
    .addr_o       (addr),
    .wdata_o      (wdata),
    .rvalid_i     (rvalid),
    .rdata_i      (rdata),
    .busy_o       (busy),
    .pass_done_o  (pass_done),
    .corr_cnt_o   (corr_cnt),
    .uncorr_cnt_o (uncorr_cnt),
    .err_addr_o   (err_addr),
    .uncorr_o     (uncorr)
  );

  always @(posedge clk) begin
    rvalid <= 1'b0;
    if (req && gnt) begin
      if (we) begin
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= addr;
        last_wr_data <= wdata;
      end else begin
        rvalid       <= 1'b1;
        rdata        <= mem[addr];
        rd_cnt       <= rd_cnt + 1;
        last_rd_addr <= addr;
      end
    end
    if (pass_done) pass_cnt <= pass_cnt + 1;
    if (uncorr) uncorr_pulses <= uncorr_pulses + 1;
  end

  // Saturation twin: every read returns a word with check bit 24 flipped.
  logic        enable_s = 1'b0;
  logic        req_s, gnt_s, we_s, busy_s, pass_s, uncorr_s;
  logic [1:0]  addr_s, err_addr_s, corr_s, uncorr_cnt_s;
  logic [27:0] wdata_s;
  logic        rvalid_s = 1'b0;
  logic [27:0] rdata_s;
  int          wr_s = 0;

  assign gnt_s   = req_s;
  assign rdata_s = 28'hb800000;

  ecc_scrub_ctrl_28_22 #(.Depth(4), .IntervalW(16), .CntW(2)) dut_sat (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable_s),
    .interval_i   (interval),
    .req_o        (req_s),
    .gnt_i        (gnt_s),
    .we_o         (we_s),
    .addr_o       (addr_s),
    .wdata_o      (wdata_s),
    .rvalid_i     (rvalid_s),
    .rdata_i      (rdata_s),
    .busy_o       (busy_s),
    .pass_done_o  (pass_s),
    .corr_cnt_o   (corr_s),
    .uncorr_cnt_o (uncorr_cnt_s),
    .err_addr_o   (err_addr_s),
    .uncorr_o     (uncorr_s)
  );

  always @(posedge clk) begin
    rvalid_s <= req_s & gnt_s & ~we_s;
    if (req_s && gnt_s && we_s) wr_s <= wr_s + 1;
  end

  task automatic load_clean();
    mem[0] = ENC_0;
    mem[1] = ENC_1;
    mem[2] = ENC_155555;
    mem[3] = ENC_2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
  endtask

  // Enable, wait for pass_done_o, disable and wait for IDLE.
  task automatic run_pass(output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (pass_done) begin
        cycles = i;
        ok = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_assert++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", req); end
    n_assert++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", we); end
    n_assert++; if (addr !== 2'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", addr); end
    n_assert++; if (wdata !== 28'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", wdata); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_assert++; if (pass_done !== 1'b0) begin n_fail++; $display("FAIL reset_pass_done: got %0b want 0", pass_done); end
    n_assert++; if (corr_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_corr_cnt: got %0d want 0", corr_cnt); end
    n_assert++; if (uncorr_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_uncorr_cnt: got %0d want 0", uncorr_cnt); end
    n_assert++; if (err_addr !== 2'd0) begin n_fail++; $display("FAIL reset_err_addr: got %0d want 0", err_addr); end
    n_assert++; if (uncorr !== 1'b0) begin n_fail++; $display("FAIL reset_uncorr: got %0b want 0", uncorr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_pass();
    int cyc, rd0, wr0, ps0;
    bit ok;
    do_reset();
    load_clean();
    rd0 = rd_cnt; wr0 = wr_cnt; ps0 = pass_cnt;
    run_pass(cyc, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL clean_timeout: pass_done seen=%0b want 1", ok); end
    n_assert++; if (cyc != 20) begin n_fail++; $display("FAIL clean_cycles: got %0d want 20", cyc); end
    n_assert++; if (rd_cnt - rd0 != 4) begin n_fail++; $display("FAIL clean_reads: got %0d want 4", rd_cnt - rd0); end
    n_assert++; if (wr_cnt - wr0 != 0) begin n_fail++; $display("FAIL clean_writes: got %0d want 0", wr_cnt - wr0); end
    n_assert++; if (pass_cnt - ps0 != 1) begin n_fail++; $display("FAIL clean_pass_pulses: got %0d want 1", pass_cnt - ps0); end
    n_assert++; if (last_rd_addr !== 2'd3) begin n_fail++; $display("FAIL clean_last_addr: got %0d want 3", last_rd_addr); end
    n_assert++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
      n_fail++; $display("FAIL clean_counters: got corr=%0d uncorr=%0d want 0/0", corr_cnt, uncorr_cnt);
    end
  endtask

  task automatic test_interval();
    int cyc, rd0;
    bit ok;
    do_reset();
    load_clean();
    interval = 16'd2;
    rd0 = rd_cnt;
    run_pass(cyc, ok);
    interval = 16'd0;
    n_assert++; if (!ok || cyc != 28) begin n_fail++; $display("FAIL interval_cycles: got %0d (ok=%0b) want 28", cyc, ok); end
    n_assert++; if (rd_cnt - rd0 != 4) begin n_fail++; $display("FAIL interval_reads: got %0d want 4", rd_cnt - rd0); end
  endtask

  task automatic test_correct_data();
    int cyc, wr0;
    bit ok;
    do_reset();
    load_clean();
    mem[2] = ENC_155555 ^ 28'h0000020;
    wr0 = wr_cnt;
    run_pass(cyc, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL corr_data_timeout: pass_done seen=%0b want 1", ok); end
    n_assert++; if (wr_cnt - wr0 != 1) begin n_fail++; $display("FAIL corr_data_writes: got %0d want 1", wr_cnt - wr0); end
    n_assert++; if (last_wr_addr !== 2'd2) begin n_fail++; $display("FAIL corr_data_addr: got %0d want 2", last_wr_addr); end
    n_assert++; if (last_wr_data !== ENC_155555) begin n_fail++; $display("FAIL corr_data_wdata: got %h want %h", last_wr_data, ENC_155555); end
    n_assert++; if (corr_cnt !== 16'd1) begin n_fail++; $display("FAIL corr_data_cnt: got %0d want 1", corr_cnt); end
  endtask

  task automatic test_correct_check();
    int cyc, wr0;
    bit ok;
    do_reset();
    load_clean();
    mem[1] = ENC_0 ^ 28'h1000000;
    wr0 = wr_cnt;
    run_pass(cyc, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL corr_chk_timeout: pass_done seen=%0b want 1", ok); end
    n_assert++; if (wr_cnt - wr0 != 1 || last_wr_addr !== 2'd1) begin
      n_fail++; $display("FAIL corr_chk_write: got %0d writes addr %0d want 1 write addr 1", wr_cnt - wr0, last_wr_addr);
    end
    n_assert++; if (last_wr_data !== ENC_0) begin n_fail++; $display("FAIL corr_chk_wdata: got %h want %h", last_wr_data, ENC_0); end
    n_assert++; if (corr_cnt !== 16'd1 || uncorr_cnt !== 16'd0) begin
      n_fail++; $display("FAIL corr_chk_counters: got corr=%0d uncorr=%0d want 1/0", corr_cnt, uncorr_cnt);
    end
  endtask

  task automatic test_uncorrectable();
    int cyc, wr0, up0;
    bit ok;
    do_reset();
    load_clean();
    mem[3] = ENC_1 ^ 28'h0000081;
    wr0 = wr_cnt; up0 = uncorr_pulses;
    run_pass(cyc, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL uncorr_timeout: pass_done seen=%0b want 1", ok); end
    n_assert++; if (wr_cnt - wr0 != 0) begin n_fail++; $display("FAIL uncorr_writes: got %0d want 0", wr_cnt - wr0); end
    n_assert++; if (uncorr_pulses - up0 != 1) begin n_fail++; $display("FAIL uncorr_pulses: got %0d want 1", uncorr_pulses - up0); end
    n_assert++; if (err_addr !== 2'd3) begin n_fail++; $display("FAIL uncorr_err_addr: got %0d want 3", err_addr); end
    n_assert++; if (uncorr_cnt !== 16'd1 || corr_cnt !== 16'd0) begin
      n_fail++; $display("FAIL uncorr_counters: got uncorr=%0d corr=%0d want 1/0", uncorr_cnt, corr_cnt);
    end
  endtask

  task automatic test_gnt_stall();
    int rd0;
    bit seen, stable;
    do_reset();
    load_clean();
    gnt_rd_en = 1'b0;
    rd0 = rd_cnt;
    @(negedge clk);
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req) begin seen = 1'b1; break; end
    end
    n_assert++; if (!seen) begin n_fail++; $display("FAIL stall_req_timeout: req seen=%0b want 1", seen); end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) enable = 1'b0;
      if (req !== 1'b1 || we !== 1'b0 || addr !== 2'd0) stable = 1'b0;
      @(negedge clk);
    end
    n_assert++; if (!stable) begin n_fail++; $display("FAIL stall_req_stable: stable=%0b want 1", stable); end
    gnt_rd_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_idle: busy=%0b want 0", busy); end
    n_assert++; if (rd_cnt - rd0 != 1 || last_rd_addr !== 2'd0) begin
      n_fail++; $display("FAIL stall_read: got %0d reads addr %0d want 1 read addr 0", rd_cnt - rd0, last_rd_addr);
    end
    rd0 = rd_cnt;
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rd_cnt != rd0) break;
    end
    enable = 1'b0;
    n_assert++; if (rd_cnt - rd0 != 1 || last_rd_addr !== 2'd1) begin
      n_fail++; $display("FAIL stall_resume: got %0d reads addr %0d want 1 read addr 1", rd_cnt - rd0, last_rd_addr);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  task automatic test_reset_in_write();
    int rd0;
    bit seen;
    do_reset();
    load_clean();
    mem[0] = ENC_0 ^ 28'h0000001;
    gnt_wr_en = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req && we) begin seen = 1'b1; break; end
    end
    n_assert++; if (!seen) begin n_fail++; $display("FAIL rstwr_timeout: write req seen=%0b want 1", seen); end
    n_assert++; if (wdata !== ENC_0 || corr_cnt !== 16'd1) begin
      n_fail++; $display("FAIL rstwr_pre: got wdata=%h corr=%0d want %h/1", wdata, corr_cnt, ENC_0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_assert++; if (req !== 1'b0 || we !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstwr_ctrl: got req=%0b we=%0b busy=%0b want 0/0/0", req, we, busy);
    end
    n_assert++; if (wdata !== 28'h0 || addr !== 2'd0 || corr_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rstwr_data: got wdata=%h addr=%0d corr=%0d want 0/0/0", wdata, addr, corr_cnt);
    end
    @(negedge clk);
    rd0 = rd_cnt;
    rst_n = 1'b1;
    gnt_wr_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rd_cnt != rd0) break;
    end
    enable = 1'b0;
    n_assert++; if (rd_cnt - rd0 != 1 || last_rd_addr !== 2'd0) begin
      n_fail++; $display("FAIL rstwr_restart: got %0d reads addr %0d want 1 read addr 0", rd_cnt - rd0, last_rd_addr);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk);
    enable_s = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_s >= 5) break;
    end
    enable_s = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy_s) break;
    end
    n_assert++; if (wr_s < 5) begin n_fail++; $display("FAIL sat_writes: got %0d want >=5", wr_s); end
    n_assert++; if (corr_s !== 2'd3) begin n_fail++; $display("FAIL sat_corr_cnt: got %0d want 3", corr_s); end
    n_assert++; if (uncorr_cnt_s !== 2'd0) begin n_fail++; $display("FAIL sat_uncorr_cnt: got %0d want 0", uncorr_cnt_s); end
  endtask

  initial begin
    #2;
    test_reset();
    test_clean_pass();
    test_interval();
    test_correct_data();
    test_correct_check();
    test_uncorrectable();
    test_gnt_stall();
    test_reset_in_write();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, assertions=%0d failures=%0d", n_assert, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
